// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the cache/memory request arbiter.
package mem_arb_pkg;

  // Requestor that owns an in-flight read; also the route FIFO payload.
  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } src_t;

  localparam int MEM_ADDR_WIDTH = 64;
  localparam int MEM_LINE_SIZE  = 512;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Cache-side, memory-side and refill handshakes of the arbiter.
interface mem_arb_if #(
  parameter int ADDR_WIDTH = mem_arb_pkg::MEM_ADDR_WIDTH,
  parameter int LINE_SIZE  = mem_arb_pkg::MEM_LINE_SIZE
);
  logic                  icache_miss_valid_i;
  logic                  icache_miss_ready_o;
  logic [ADDR_WIDTH-1:0] icache_miss_addr_i;
  logic                  dcache_req_valid_i;
  logic                  dcache_req_ready_o;
  logic [ADDR_WIDTH-1:0] dcache_req_addr_i;
  logic                  dcache_req_wen_i;
  logic [LINE_SIZE-1:0]  dcache_req_wdata_i;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [ADDR_WIDTH-1:0] mem_req_addr_o;
  logic                  mem_req_wen_o;
  logic [LINE_SIZE-1:0]  mem_req_wdata_o;
  logic                  mem_resp_valid_i;
  logic                  mem_resp_ready_o;
  logic [LINE_SIZE-1:0]  mem_resp_data_i;
  logic                  refill_icache_valid_o;
  logic                  refill_icache_ready_i;
  logic [LINE_SIZE-1:0]  refill_icache_data_o;
  logic                  refill_dcache_valid_o;
  logic                  refill_dcache_ready_i;
  logic [LINE_SIZE-1:0]  refill_dcache_data_o;

  // Arbiter side.
  modport slave (
    input  icache_miss_valid_i, icache_miss_addr_i,
    output icache_miss_ready_o,
    input  dcache_req_valid_i, dcache_req_addr_i, dcache_req_wen_i, dcache_req_wdata_i,
    output dcache_req_ready_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_wen_o, mem_req_wdata_o,
    input  mem_req_ready_i,
    input  mem_resp_valid_i, mem_resp_data_i,
    output mem_resp_ready_o,
    output refill_icache_valid_o, refill_icache_data_o,
    input  refill_icache_ready_i,
    output refill_dcache_valid_o, refill_dcache_data_o,
    input  refill_dcache_ready_i
  );

  // Caches + memory subsystem side.
  modport master (
    output icache_miss_valid_i, icache_miss_addr_i,
    input  icache_miss_ready_o,
    output dcache_req_valid_i, dcache_req_addr_i, dcache_req_wen_i, dcache_req_wdata_i,
    input  dcache_req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_wen_o, mem_req_wdata_o,
    output mem_req_ready_i,
    output mem_resp_valid_i, mem_resp_data_i,
    input  mem_resp_ready_o,
    input  refill_icache_valid_o, refill_icache_data_o,
    output refill_icache_ready_i,
    input  refill_dcache_valid_o, refill_dcache_data_o,
    output refill_dcache_ready_i
  );
endinterface

// File: rtl/mem_req_arbiter_route_fifo.sv
// In-order record of which cache owns each outstanding read.
module route_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  src_t din_i,
  input  logic pop_i,
  output src_t head_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = $clog2(DEPTH);

  src_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // Occupancy next-state: push and pop together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; the count qualifies it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin Icache/Dcache arbiter into one registered memory request
// slot, with in-order steering of read responses back to the requestor.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int LINE_SIZE   = MEM_LINE_SIZE,
  parameter int OUTSTANDING = 4,
  parameter int CNT_WIDTH   = 3
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);
  logic                  slot_vld_q, slot_vld_d;
  logic [ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
  logic                  slot_wen_q, slot_wen_d;
  logic [LINE_SIZE-1:0]  slot_wdata_q, slot_wdata_d;
  src_t                  rr_last_q, rr_last_d;

  logic slot_free, i_elig, d_elig, gnt_i, gnt_d;
  logic fifo_full, fifo_empty, push, pop;
  src_t head;

  assign slot_free = !slot_vld_q || bus.mem_req_ready_i;

  // Grant: favour the source that did not win last time when both are eligible.
  always_comb begin
    gnt_i  = 1'b0;
    gnt_d  = 1'b0;
    i_elig = bus.icache_miss_valid_i && !fifo_full;
    d_elig = bus.dcache_req_valid_i && (bus.dcache_req_wen_i || !fifo_full);
    if (!rst && slot_free) begin
      if (i_elig && d_elig) begin
        gnt_i = (rr_last_q == SRC_DCACHE);
        gnt_d = !gnt_i;
      end else begin
        gnt_i = i_elig;
        gnt_d = d_elig;
      end
    end
  end

  assign bus.icache_miss_ready_o = gnt_i;
  assign bus.dcache_req_ready_o  = gnt_d;

  // Slot next-state: load on grant, otherwise drop once memory takes it.
  always_comb begin
    slot_vld_d   = slot_vld_q;
    slot_addr_d  = slot_addr_q;
    slot_wen_d   = slot_wen_q;
    slot_wdata_d = slot_wdata_q;
    rr_last_d    = rr_last_q;
    if (gnt_i) begin
      slot_vld_d   = 1'b1;
      slot_addr_d  = bus.icache_miss_addr_i;
      slot_wen_d   = 1'b0;
      slot_wdata_d = '0;
      rr_last_d    = SRC_ICACHE;
    end else if (gnt_d) begin
      slot_vld_d   = 1'b1;
      slot_addr_d  = bus.dcache_req_addr_i;
      slot_wen_d   = bus.dcache_req_wen_i;
      slot_wdata_d = bus.dcache_req_wdata_i;
      rr_last_d    = SRC_DCACHE;
    end else if (bus.mem_req_ready_i) begin
      slot_vld_d   = 1'b0;
    end
  end

  // Slot and round-robin state; reset leaves Icache to win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q   <= 1'b0;
      slot_addr_q  <= '0;
      slot_wen_q   <= 1'b0;
      slot_wdata_q <= '0;
      rr_last_q    <= SRC_DCACHE;
    end else begin
      slot_vld_q   <= slot_vld_d;
      slot_addr_q  <= slot_addr_d;
      slot_wen_q   <= slot_wen_d;
      slot_wdata_q <= slot_wdata_d;
      rr_last_q    <= rr_last_d;
    end
  end

  assign bus.mem_req_valid_o = slot_vld_q;
  assign bus.mem_req_addr_o  = slot_addr_q;
  assign bus.mem_req_wen_o   = slot_wen_q;
  assign bus.mem_req_wdata_o = slot_wdata_q;

  // Only reads expect a response, so only reads are recorded.
  assign push = gnt_i || (gnt_d && !bus.dcache_req_wen_i);

  route_fifo #(
    .DEPTH (OUTSTANDING),
    .CNT_W (CNT_WIDTH)
  ) u_route_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (gnt_i ? SRC_ICACHE : SRC_DCACHE),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Response steering is purely combinational off the FIFO head; a response
  // with nothing outstanding is never acknowledged.
  assign bus.refill_icache_valid_o = bus.mem_resp_valid_i && !fifo_empty && (head == SRC_ICACHE);
  assign bus.refill_dcache_valid_o = bus.mem_resp_valid_i && !fifo_empty && (head == SRC_DCACHE);
  assign bus.mem_resp_ready_o      = !fifo_empty &&
                                     ((head == SRC_ICACHE) ? bus.refill_icache_ready_i
                                                           : bus.refill_dcache_ready_i);
  assign pop = bus.mem_resp_valid_i && bus.mem_resp_ready_o;

  assign bus.refill_icache_data_o = bus.mem_resp_data_i;
  assign bus.refill_dcache_data_o = bus.mem_resp_data_i;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed + random bench for mem_req_arbiter against a queue-based model.
module tb_mem_req_arbiter;
  localparam int AW   = 64;
  localparam int LW   = 512;
  localparam int OUTS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_WIDTH(AW), .LINE_SIZE(LW)) bus ();

  mem_req_arbiter #(
    .ADDR_WIDTH (AW),
    .LINE_SIZE  (LW),
    .OUTSTANDING(OUTS),
    .CNT_WIDTH  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: the request sitting in the slot, the owners of the
  // reads still awaiting data (oldest first), and who won most recently.
  bit            m_vld;
  logic [AW-1:0] m_addr;
  bit            m_wen;
  logic [LW-1:0] m_wdata;
  bit            m_last_d;   // 1: Dcache won last
  bit            owners[$];  // 0 = Icache, 1 = Dcache

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    owners.delete();
    m_vld = 0; m_addr = '0; m_wen = 0; m_wdata = '0; m_last_d = 1;
  endtask

  // Compare every output against the model for the current inputs, advance
  // the model by one cycle, and move to the next falling edge.
  task automatic tick();
    bit can_take, room, want_i, want_d, win_i, win_d, have, head_d, ack, pop;
    #1;
    can_take = !m_vld || bus.mem_req_ready_i;
    room     = owners.size() < OUTS;
    want_i   = bus.icache_miss_valid_i && room;
    want_d   = bus.dcache_req_valid_i && (bus.dcache_req_wen_i || room);
    win_i = 0; win_d = 0;
    if (!rst && can_take) begin
      if (want_i && want_d) begin
        if (m_last_d) win_i = 1; else win_d = 1;
      end else begin
        win_i = want_i; win_d = want_d;
      end
    end
    have   = owners.size() != 0;
    head_d = have ? owners[0] : 1'b0;
    ack    = have && (head_d ? bus.refill_dcache_ready_i : bus.refill_icache_ready_i);
    pop    = bus.mem_resp_valid_i && ack;

    chk("icache_ready", bus.icache_miss_ready_o, win_i);
    chk("dcache_ready", bus.dcache_req_ready_o, win_d);
    chk("req_valid", bus.mem_req_valid_o, m_vld);
    chk("req_addr", bus.mem_req_addr_o, m_addr);
    chk("req_wen", bus.mem_req_wen_o, m_wen);
    chk("req_wdata", bus.mem_req_wdata_o, m_wdata);
    chk("resp_ready", bus.mem_resp_ready_o, ack);
    chk("refill_i_valid", bus.refill_icache_valid_o, bus.mem_resp_valid_i && have && !head_d);
    chk("refill_d_valid", bus.refill_dcache_valid_o, bus.mem_resp_valid_i && have && head_d);
    chk("refill_i_data", bus.refill_icache_data_o, bus.mem_resp_data_i);
    chk("refill_d_data", bus.refill_dcache_data_o, bus.mem_resp_data_i);

    if (rst) begin
      model_reset();
    end else begin
      if (pop) void'(owners.pop_front());
      if (win_i) begin
        m_vld = 1; m_addr = bus.icache_miss_addr_i; m_wen = 0; m_wdata = '0;
        owners.push_back(1'b0); m_last_d = 0;
      end else if (win_d) begin
        m_vld = 1; m_addr = bus.dcache_req_addr_i; m_wen = bus.dcache_req_wen_i;
        m_wdata = bus.dcache_req_wdata_i;
        if (!bus.dcache_req_wen_i) owners.push_back(1'b1);
        m_last_d = 1;
      end else if (bus.mem_req_ready_i) begin
        m_vld = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.icache_miss_valid_i   = 0;
    bus.dcache_req_valid_i    = 0;
    bus.dcache_req_wen_i      = 0;
    bus.mem_req_ready_i       = 1;
    bus.mem_resp_valid_i      = 0;
    bus.refill_icache_ready_i = 1;
    bus.refill_dcache_ready_i = 1;
  endtask

  // Return every outstanding read; bounded so a stuck DUT cannot hang us.
  task automatic drain();
    idle();
    for (int n = 0; n < 12 && (owners.size() != 0 || m_vld); n++) begin
      bus.mem_resp_valid_i = (owners.size() != 0);
      bus.mem_resp_data_i  = rnd_line();
      tick();
    end
    chk("drain_done", owners.size() == 0 && !m_vld, 1'b1);
    idle();
  endtask

  initial begin
    idle();
    bus.icache_miss_addr_i = '0;
    bus.dcache_req_addr_i  = '0;
    bus.dcache_req_wdata_i = '0;
    bus.mem_resp_data_i    = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Reset state.
    #1;
    chk("rst_req_valid", bus.mem_req_valid_o, 1'b0);
    chk("rst_req_addr", bus.mem_req_addr_o, '0);
    chk("rst_resp_ready", bus.mem_resp_ready_o, 1'b0);
    chk("rst_refill_i_valid", bus.refill_icache_valid_o, 1'b0);
    tick();

    // Single Icache miss, then its line returns on the Icache port only.
    bus.icache_miss_valid_i = 1;
    bus.icache_miss_addr_i  = 64'h8000_0040;
    #1 chk("t1_irdy", bus.icache_miss_ready_o, 1'b1);
    tick();
    bus.icache_miss_valid_i = 0;
    #1;
    chk("t1_irdy_pulse", bus.icache_miss_ready_o, 1'b0);
    chk("t1_addr", bus.mem_req_addr_o, 64'h8000_0040);
    chk("t1_wen", bus.mem_req_wen_o, 1'b0);
    tick();
    bus.mem_resp_valid_i = 1;
    bus.mem_resp_data_i  = {64{8'hA5}};
    #1;
    chk("t1_ref_i", bus.refill_icache_valid_o, 1'b1);
    chk("t1_ref_d", bus.refill_dcache_valid_o, 1'b0);
    tick();
    bus.mem_resp_valid_i = 0;
    #1 chk("t1_empty", bus.mem_resp_ready_o, 1'b0);
    tick();

    // Both caches read every cycle from a fresh reset: I, D, I, D ...
    rst = 1; tick(); rst = 0;
    bus.icache_miss_valid_i = 1;
    bus.dcache_req_valid_i  = 1;
    bus.dcache_req_wen_i    = 0;
    bus.mem_resp_valid_i    = 1;
    for (int n = 0; n < 10; n++) begin
      bus.icache_miss_addr_i = rnd_addr();
      bus.dcache_req_addr_i  = rnd_addr();
      bus.mem_resp_data_i    = rnd_line();
      if (n == 0) #1 chk("t2_first_i", bus.icache_miss_ready_o, 1'b1);
      if (n == 1) #1 chk("t2_second_d", bus.dcache_req_ready_o, 1'b1);
      tick();
    end
    drain();

    // Fill the route FIFO with Dcache reads; writes still go through.
    bus.dcache_req_valid_i = 1;
    for (int n = 0; n < OUTS; n++) begin
      bus.dcache_req_addr_i = rnd_addr();
      tick();
    end
    #1 chk("t3_fifth_blocked", bus.dcache_req_ready_o, 1'b0);
    tick();
    bus.dcache_req_wen_i   = 1;
    bus.dcache_req_wdata_i = rnd_line();
    #1 chk("t3_write_ok", bus.dcache_req_ready_o, 1'b1);
    tick();
    bus.dcache_req_wen_i = 0;
    bus.mem_resp_valid_i = 1;
    bus.mem_resp_data_i  = rnd_line();
    #1;
    chk("t3_still_full", bus.dcache_req_ready_o, 1'b0);
    chk("t3_pop", bus.mem_resp_ready_o, 1'b1);
    tick();
    bus.mem_resp_valid_i = 0;
    #1 chk("t3_fifth_granted", bus.dcache_req_ready_o, 1'b1);
    tick();
    drain();

    // Memory back-pressure: slot held, no grants, then drain+grant together.
    bus.icache_miss_valid_i = 1;
    bus.icache_miss_addr_i  = 64'h0000_1234_5678_9AC0;
    tick();
    bus.mem_req_ready_i    = 0;
    bus.dcache_req_valid_i = 1;
    for (int n = 0; n < 3; n++) begin
      bus.icache_miss_addr_i = rnd_addr();
      bus.dcache_req_addr_i  = rnd_addr();
      #1;
      chk("t4_no_igrant", bus.icache_miss_ready_o, 1'b0);
      chk("t4_no_dgrant", bus.dcache_req_ready_o, 1'b0);
      chk("t4_addr_hold", bus.mem_req_addr_o, 64'h0000_1234_5678_9AC0);
      tick();
    end
    bus.mem_req_ready_i = 1;
    #1 chk("t4_release_grant", bus.dcache_req_ready_o, 1'b1);
    tick();
    drain();

    // Refill stall on the Icache port, then a response with nothing pending.
    bus.icache_miss_valid_i = 1;
    tick();
    bus.icache_miss_valid_i   = 0;
    tick();
    bus.mem_resp_valid_i      = 1;
    bus.mem_resp_data_i       = rnd_line();
    bus.refill_icache_ready_i = 0;
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("t5_stall_ready", bus.mem_resp_ready_o, 1'b0);
      chk("t5_stall_valid", bus.refill_icache_valid_o, 1'b1);
      tick();
    end
    bus.refill_icache_ready_i = 1;
    #1 chk("t5_release", bus.mem_resp_ready_o, 1'b1);
    tick();
    #1 chk("t5_empty_resp", bus.mem_resp_ready_o, 1'b0);
    tick();
    idle();

    // Reset with two reads outstanding.
    bus.icache_miss_valid_i = 1;
    bus.dcache_req_valid_i  = 1;
    tick();
    tick();
    bus.icache_miss_valid_i = 0;
    bus.dcache_req_valid_i  = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("t6_req_valid", bus.mem_req_valid_o, 1'b0);
    chk("t6_empty", bus.mem_resp_ready_o, 1'b0);
    bus.icache_miss_valid_i = 1;
    bus.dcache_req_valid_i  = 1;
    #1 chk("t6_tie_icache", bus.icache_miss_ready_o, 1'b1);
    tick();
    drain();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rst                       = ($urandom_range(0, 63) == 0);
      bus.icache_miss_valid_i   = $urandom_range(0, 1);
      bus.icache_miss_addr_i    = rnd_addr();
      bus.dcache_req_valid_i    = $urandom_range(0, 1);
      bus.dcache_req_addr_i     = rnd_addr();
      bus.dcache_req_wen_i      = ($urandom_range(0, 3) == 0);
      bus.dcache_req_wdata_i    = rnd_line();
      bus.mem_req_ready_i       = ($urandom_range(0, 3) != 0);
      bus.mem_resp_valid_i      = $urandom_range(0, 1);
      bus.mem_resp_data_i       = rnd_line();
      bus.refill_icache_ready_i = ($urandom_range(0, 3) != 0);
      bus.refill_dcache_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares the single memory-subsystem request/response port between the Icache miss path and the Dcache miss/writeback path. Arbitrates requests round-robin into a one-entry registered request slot, and records the source of every read in an in-order route FIFO. Returning line data is steered to the Icache refill port or the Dcache refill port. Sits between both caches and the memory subsystem; the memory subsystem returns read responses in request order, and writes return nothing.

## Interface
- `ADDR_WIDTH`, 64, request address width
- `LINE_SIZE`, 512, cache line width in bits
- `OUTSTANDING`, 4, maximum in-flight reads (route FIFO depth, power of two)
- `CNT_WIDTH`, 3, width of the occupancy counter (log2(OUTSTANDING)+1)

Ports:
- `clk` input 1 — single clock, all state on rising edge
- `rst` input 1 — synchronous, active-high reset
- `icache_miss_valid_i` input 1 — Icache read-miss request
- `icache_miss_ready_o` output 1 — Icache request accepted this cycle
- `icache_miss_addr_i` input ADDR_WIDTH — Icache miss address
- `dcache_req_valid_i` input 1 — Dcache request
- `dcache_req_ready_o` output 1 — Dcache request accepted this cycle
- `dcache_req_addr_i` input ADDR_WIDTH — Dcache address
- `dcache_req_wen_i` input 1 — 1 = writeback, 0 = read miss
- `dcache_req_wdata_i` input LINE_SIZE — writeback line
- `mem_req_valid_o` output 1 — request slot occupied
- `mem_req_ready_i` input 1 — memory accepts the slot
- `mem_req_addr_o` output ADDR_WIDTH — slot address
- `mem_req_wen_o` output 1 — slot is a write
- `mem_req_wdata_o` output LINE_SIZE — slot write data
- `mem_resp_valid_i` input 1 — read data returning
- `mem_resp_ready_o` output 1 — response consumed
- `mem_resp_data_i` input LINE_SIZE — returning line
- `refill_icache_valid_o` output 1 / `refill_icache_ready_i` input 1 / `refill_icache_data_o` output LINE_SIZE — Icache refill port
- `refill_dcache_valid_o` output 1 / `refill_dcache_ready_i` input 1 / `refill_dcache_data_o` output LINE_SIZE — Dcache refill port

## Operation
- Slot free = `!mem_req_valid_o || mem_req_ready_i`; a new grant is possible only when the slot is free.
- Eligibility:
  - Icache is eligible if valid and the route FIFO is not full.
  - A Dcache read is eligible if valid and the route FIFO is not full.
  - A Dcache write is eligible if valid; FIFO fullness does not gate writes.
- Round-robin: the `rr_last` bit records the last granted source. With both sources eligible, grant the source that is not `rr_last`. With a single source eligible, grant it. `rr_last` updates on every grant.
- On grant:
  - Assert the winner's ready_o combinationally in that cycle.
  - Load addr/wen/wdata into the slot and set `mem_req_valid_o`.
  - If the request is a read, push the source ID into the route FIFO.
  - Icache requests always load wen = 0 and wdata = 0.
- The slot clears when `mem_req_ready_i` is high and there is no new grant. Drain and grant in the same cycle give back-to-back issue.
- Fullness is computed from the registered count, with no pop bypass. A push into a full FIFO is impossible by construction.
- Response routing, with `head` = FIFO head entry:
  - `refill_icache_valid_o = mem_resp_valid_i && !empty && head==SRC_ICACHE`; `refill_dcache_valid_o` is the same with SRC_DCACHE.
  - `mem_resp_ready_o = !empty && (head==SRC_ICACHE ? refill_icache_ready_i : refill_dcache_ready_i)`.
  - Pop on `mem_resp_valid_i && mem_resp_ready_o`.
  - Data is passed through to both refill data ports unmodified.
- A response arriving while the FIFO is empty is a protocol violation. `mem_resp_ready_o` stays 0 and the response is not consumed.
- Simultaneous push and pop: the count is unchanged and both pointers advance. Pointers wrap modulo OUTSTANDING.

## Timing
- Reset values:
  - All valid_o, ready_o and `mem_resp_ready_o` = 0.
  - Slot fields = 0.
  - Count = 0, pointers = 0.
  - `rr_last` = SRC_DCACHE, so Icache wins the first tie.
- Request latency: accept in cycle N, `mem_req_valid_o` high in N+1.
- Slot fields are held stable while `mem_req_valid_o && !mem_req_ready_i`.
- Response path is combinational, 0-cycle, with no registers.
- A read accepted in cycle N counts toward FIFO occupancy from cycle N+1.
- Reset asserted mid-transaction drops the slot and empties the FIFO in the next cycle. In-flight memory responses are the memory subsystem's responsibility to flush.

## Structure
- Shared package `mem_arb_pkg` holds the `src_t` enum (SRC_ICACHE=1'b0, SRC_DCACHE=1'b1) and the ADDR_WIDTH/LINE_SIZE defaults, shared with the Icache and Dcache.
- Sub-module `route_fifo`: synchronous FIFO, width 1, depth OUTSTANDING. It provides push, pop, head, full and empty, with a registered count.
- The arbiter, request slot and response steering stay in the top module.

## Test plan
- Icache-only miss at addr 0x8000_0040, `mem_req_ready_i` = 1:
  - `icache_miss_ready_o` pulses one cycle and `mem_req_addr_o` = 0x8000_0040 next cycle with wen = 0.
  - Response 0xA5… appears on the Icache refill port only; count returns to 0.
- Both caches request reads every cycle:
  - Grants alternate I, D, I, D starting with Icache.
  - Responses return in order and route alternately to the two ports.
- Five Dcache reads with no responses and OUTSTANDING = 4:
  - The 5th is not accepted (`dcache_req_ready_o` = 0).
  - A Dcache write issued meanwhile is accepted.
  - After one response pops, the 5th read is granted.
- Hold `mem_req_ready_i` = 0 for 3 cycles:
  - Slot addr/wdata stay stable and no further grants occur.
  - On release, drain and the next grant happen in the same cycle.
- Head = Icache with `refill_icache_ready_i` = 0 for 2 cycles:
  - `mem_resp_ready_o` = 0 and `refill_icache_valid_o` = 1 during the stall; the FIFO does not pop.
  - A response with the FIFO empty is never consumed.
- Assert `rst` with 2 reads outstanding: the next cycle shows count = 0, all valids = 0, and Icache winning the next tie.
